// File: rtl/buffer_readout_pkg.sv
// Shared sizing constants and readout FSM encoding for the sample-buffer readout.
package buffer_readout_pkg;

    localparam int RAM_SIZE = 256;
    localparam int ADDR_BUS = 8;
    localparam int DATA_W   = 16;
    localparam int COORD_W  = 13;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_PUSH      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/buffer_readout_peak_tracker.sv
// Running maximum over one frame; ties keep the earliest frame offset.
module peak_tracker
    import buffer_readout_pkg::*;
#(
    parameter int SAMPLE_W = DATA_W,
    parameter int IDX_W    = ADDR_BUS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [IDX_W-1:0]    i_index,
    output logic [SAMPLE_W-1:0] o_peak_value,
    output logic [IDX_W-1:0]    o_peak_index
);

    logic [SAMPLE_W-1:0] r_peak_value;
    logic [IDX_W-1:0]    r_peak_index;
    logic                w_take;

    // Word 0 always loads so a frame of all-zero samples still reports index 0.
    always_comb begin
        w_take = i_valid && ((i_index == '0) || (i_sample > r_peak_value));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_peak_value <= '0;
            r_peak_index <= '0;
        end else if (i_clear) begin
            r_peak_value <= '0;
            r_peak_index <= '0;
        end else if (w_take) begin
            r_peak_value <= i_sample;
            r_peak_index <= i_index;
        end
    end

    assign o_peak_value = r_peak_value;
    assign o_peak_index = r_peak_index;

endmodule

// File: rtl/buffer_readout.sv
// Reads a stopped circular sample buffer over Avalon-MM, oldest word first,
// and streams it with SOP/EOP framing while tracking the frame peak.
module buffer_readout #(
    parameter int RAM_SIZE = buffer_readout_pkg::RAM_SIZE,
    parameter int ADDR_BUS = buffer_readout_pkg::ADDR_BUS,
    parameter int DATA_W   = buffer_readout_pkg::DATA_W
) (
    input  logic                                   ref_clk,
    input  logic                                   reset,
    input  logic                                   buffer_full,
    input  logic [ADDR_BUS-1:0]                    ram_ptr,
    input  logic [buffer_readout_pkg::COORD_W-1:0] pulse_abs_coord,
    output logic                                   av_cs,
    output logic                                   av_read,
    output logic [ADDR_BUS-1:0]                    av_addr,
    input  logic [DATA_W-1:0]                      av_readdata,
    input  logic                                   av_readdatavalid,
    output logic [DATA_W-1:0]                      st_data,
    output logic                                   st_valid,
    input  logic                                   st_ready,
    output logic                                   st_sop,
    output logic                                   st_eop,
    output logic [DATA_W-1:0]                      peak_value,
    output logic [ADDR_BUS-1:0]                    peak_index,
    output logic [buffer_readout_pkg::COORD_W-1:0] frame_coord,
    output logic                                   done,
    input  logic                                   rearm
);

    import buffer_readout_pkg::*;

    localparam int                CNT_W     = ADDR_BUS + 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(RAM_SIZE - 1);
    localparam logic [CNT_W-1:0]  SIZE_EXT  = CNT_W'(RAM_SIZE);

    state_t               r_state;
    state_t               w_next;
    logic                 r_bf_q;
    logic                 w_bf_rise;
    logic [ADDR_BUS-1:0]  r_start;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_W-1:0]    r_data;
    logic [COORD_W-1:0]   r_coord;
    logic                 w_start;
    logic                 w_capture;
    logic                 w_beat;
    logic                 w_first;
    logic                 w_last;
    logic [CNT_W-1:0]     w_sum;
    logic [CNT_W-1:0]     w_sum_wrap;
    logic [ADDR_BUS-1:0]  w_addr;
    logic [ADDR_BUS-1:0]  w_index;

    // The edge register tracks buffer_full in every state, so edges seen
    // outside IDLE are consumed and a level held high never retriggers.
    assign w_bf_rise = buffer_full && !r_bf_q;
    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == LAST_WORD);
    assign w_index   = r_cnt[ADDR_BUS-1:0];

    // Circular address: start + offset folded back into [0, RAM_SIZE).
    always_comb begin
        w_sum      = {1'b0, r_start} + r_cnt;
        w_sum_wrap = w_sum - SIZE_EXT;
        w_addr     = (w_sum >= SIZE_EXT) ? w_sum_wrap[ADDR_BUS-1:0] : w_sum[ADDR_BUS-1:0];
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_beat    = 1'b0;
        av_cs     = 1'b0;
        av_read   = 1'b0;
        av_addr   = '0;
        st_valid  = 1'b0;
        st_sop    = 1'b0;
        st_eop    = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_bf_rise) begin
                    w_start = 1'b1;
                    w_next  = ST_READ;
                end
            end
            ST_READ: begin
                av_cs   = 1'b1;
                av_read = 1'b1;
                av_addr = w_addr;
                w_next  = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (av_readdatavalid) begin
                    w_capture = 1'b1;
                    w_next    = ST_PUSH;
                end
            end
            ST_PUSH: begin
                st_valid = 1'b1;
                st_sop   = w_first;
                st_eop   = w_last;
                if (st_ready) begin
                    w_beat = 1'b1;
                    w_next = w_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (rearm) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            r_bf_q  <= 1'b0;
            r_start <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_coord <= '0;
        end else begin
            r_bf_q <= buffer_full;
            if (w_start) begin
                r_start <= ram_ptr;
                r_coord <= pulse_abs_coord;
                r_cnt   <= '0;
            end
            if (w_capture) begin
                r_data <= av_readdata;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    peak_tracker #(
        .SAMPLE_W (DATA_W),
        .IDX_W    (ADDR_BUS)
    ) u_peak (
        .i_clk        (ref_clk),
        .i_rst        (reset),
        .i_clear      (w_start),
        .i_valid      (w_capture),
        .i_sample     (av_readdata),
        .i_index      (w_index),
        .o_peak_value (peak_value),
        .o_peak_index (peak_index)
    );

    assign st_data     = r_data;
    assign frame_coord = r_coord;

endmodule

// File: tb/tb_buffer_readout.sv
// Frame-level bench: RAM/stream models around buffer_readout with table-driven frames.
module tb_buffer_readout;

    import buffer_readout_pkg::*;

    localparam int PAT_RAMP   = 0;
    localparam int PAT_SPIKES = 1;
    localparam int PAT_ZERO   = 2;
    localparam int PAT_RSMALL = 3;
    localparam int PAT_RWIDE  = 4;

    typedef struct {
        logic [7:0]  ptr;
        int          pat;
        logic [12:0] coord;
        int          mode;
        int          lat;
        bit          use_model;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        logic [15:0] exp_peak;
        logic [7:0]  exp_idx;
        int          exp_cycles;
    } vec_t;

    logic        ref_clk = 1'b0;
    logic        reset;
    logic        buffer_full;
    logic [7:0]  ram_ptr;
    logic [12:0] pulse_abs_coord;
    logic        av_cs, av_read;
    logic [7:0]  av_addr;
    logic [15:0] av_readdata;
    logic        av_readdatavalid;
    logic [15:0] st_data;
    logic        st_valid, st_ready, st_sop, st_eop;
    logic [15:0] peak_value;
    logic [7:0]  peak_index;
    logic [12:0] frame_coord;
    logic        done, rearm;

    logic [15:0] mem [0:255];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [7:0]  exp_ptr = 8'h00;
    int          frame_id = 0;
    int          ready_mode = 0;
    int          lat_max = 0;

    int          m_frame = -1;
    int          m_beats = 0;
    int          m_reads = 0;
    int          stall_cnt = 0;
    logic [15:0] m_first = '0;
    logic [15:0] m_last = '0;

    vec_t        vecs [6];

    always #5 ref_clk = ~ref_clk;

    buffer_readout #(
        .RAM_SIZE (256),
        .ADDR_BUS (8),
        .DATA_W   (16)
    ) dut (
        .ref_clk          (ref_clk),
        .reset            (reset),
        .buffer_full      (buffer_full),
        .ram_ptr          (ram_ptr),
        .pulse_abs_coord  (pulse_abs_coord),
        .av_cs            (av_cs),
        .av_read          (av_read),
        .av_addr          (av_addr),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_sop           (st_sop),
        .st_eop           (st_eop),
        .peak_value       (peak_value),
        .peak_index       (peak_index),
        .frame_coord      (frame_coord),
        .done             (done),
        .rearm            (rearm)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    // RAM responder, stream sink and stream checker share one process.
    initial begin : bus
        logic        pending;
        logic [7:0]  paddr;
        int          wcnt;
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        prev_sop, prev_eop;
        logic [7:0]  a;
        pending = 1'b0; paddr = '0; wcnt = 0; prev_stall = 1'b0;
        prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0;
        av_readdatavalid = 1'b0; av_readdata = '0; st_ready = 1'b0;
        forever begin
            @(negedge ref_clk);
            if (m_frame != frame_id) begin
                m_frame = frame_id; m_beats = 0; m_reads = 0; stall_cnt = 0; prev_stall = 1'b0;
            end
            if (reset) begin
                pending = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (av_read) begin
                    a = exp_ptr + 8'(m_reads);
                    check("rd_cs", 32'(av_cs), 32'd1);
                    check("rd_addr", 32'(av_addr), 32'(a));
                    check("rd_single_outstanding", 32'(pending), 32'd0);
                    pending = 1'b1;
                    paddr = av_addr;
                    wcnt = $urandom_range(lat_max, 0);
                    m_reads++;
                end
                if (prev_stall) begin
                    check("stall_valid", 32'(st_valid), 32'd1);
                    check("stall_data", 32'(st_data), 32'(prev_data));
                    check("stall_sop", 32'(st_sop), 32'(prev_sop));
                    check("stall_eop", 32'(st_eop), 32'(prev_eop));
                    check("stall_no_read", 32'(av_read), 32'd0);
                end
                if (st_valid) begin
                    a = exp_ptr + 8'(m_beats);
                    if (st_ready) begin
                        check("beat_data", 32'(st_data), 32'(mem[a]));
                        check("beat_sop", 32'(st_sop), 32'(m_beats == 0));
                        check("beat_eop", 32'(st_eop), 32'(m_beats == 255));
                        if (m_beats >= 256) check("beat_extra", 32'(m_beats), 32'd255);
                        if (m_beats == 0) m_first = st_data;
                        m_last = st_data;
                        m_beats++;
                        prev_stall = 1'b0;
                    end else begin
                        prev_stall = 1'b1;
                        prev_data = st_data; prev_sop = st_sop; prev_eop = st_eop;
                        if (m_beats == 3) stall_cnt++;
                    end
                end else begin
                    prev_stall = 1'b0;
                end
            end
            @(posedge ref_clk);
            #1;
            if (pending && !reset) begin
                if (wcnt == 0) begin
                    av_readdatavalid = 1'b1;
                    av_readdata = mem[paddr];
                    pending = 1'b0;
                end else begin
                    wcnt--;
                    av_readdatavalid = 1'b0;
                    av_readdata = 16'($urandom);
                end
            end else begin
                av_readdatavalid = 1'b0;
                av_readdata = 16'($urandom);
            end
            case (ready_mode)
                0: st_ready = 1'b1;
                1: st_ready = ($urandom_range(3, 0) != 0);
                2: st_ready = !(m_beats == 3 && stall_cnt < 5);
                default: st_ready = 1'b0;
            endcase
        end
    end

    task automatic fill_mem(input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                PAT_RAMP:   mem[i] = 16'(i);
                PAT_SPIKES: mem[i] = (i == 32'h20 || i == 32'h40) ? 16'h0800 : 16'h0005;
                PAT_ZERO:   mem[i] = 16'h0000;
                PAT_RSMALL: mem[i] = 16'($urandom_range(63, 0));
                default:    mem[i] = 16'($urandom);
            endcase
        end
    endtask

    // Expected frame summary from the whole-RAM view: the frame covers every
    // address once, so the peak is the RAM maximum at its first offset from ptr.
    task automatic model(input logic [7:0] p, output logic [15:0] v, output logic [7:0] ix,
                         output logic [15:0] f, output logic [15:0] l);
        logic [7:0] a;
        v = '0;
        for (int i = 0; i < 256; i++) if (mem[i] > v) v = mem[i];
        ix = '0;
        for (int o = 255; o >= 0; o--) begin
            a = p + 8'(o);
            if (mem[a] == v) ix = 8'(o);
        end
        f = mem[p];
        a = p - 8'd1;
        l = mem[a];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_av_cs"}, 32'(av_cs), 32'd0);
        check({tag, "_av_read"}, 32'(av_read), 32'd0);
        check({tag, "_av_addr"}, 32'(av_addr), 32'd0);
        check({tag, "_st_data"}, 32'(st_data), 32'd0);
        check({tag, "_st_valid"}, 32'(st_valid), 32'd0);
        check({tag, "_st_sop"}, 32'(st_sop), 32'd0);
        check({tag, "_st_eop"}, 32'(st_eop), 32'd0);
        check({tag, "_peak_value"}, 32'(peak_value), 32'd0);
        check({tag, "_peak_index"}, 32'(peak_index), 32'd0);
        check({tag, "_frame_coord"}, 32'(frame_coord), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic start_frame(input logic [7:0] p, input logic [12:0] c);
        exp_ptr = p;
        ram_ptr = p;
        pulse_abs_coord = c;
        frame_id++;
        buffer_full = 1'b0;
        tick(1);
        buffer_full = 1'b1;
        tick(1);
    endtask

    task automatic wait_done(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            tick(1);
            cyc++;
        end
        check({name, "_done_within_budget"}, 32'(done), 32'd1);
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        tick(1);
        rearm = 1'b0;
        check("rearm_clears_done", 32'(done), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] e_first, e_last, e_peak;
        logic [7:0]  e_idx;
        int          cyc;
        fill_mem(v.pat);
        lat_max = v.lat;
        ready_mode = v.mode;
        if (v.use_model) begin
            model(v.ptr, e_peak, e_idx, e_first, e_last);
        end else begin
            e_first = v.exp_first; e_last = v.exp_last; e_peak = v.exp_peak; e_idx = v.exp_idx;
        end
        start_frame(v.ptr, v.coord);
        wait_done("frame", 8000, cyc);
        if (v.exp_cycles != 0) check("frame_latency", 32'(cyc), 32'(v.exp_cycles));
        if (v.mode == 2) check("stall_cycles_at_beat3", 32'(stall_cnt), 32'd5);
        check("frame_beats", 32'(m_beats), 32'd256);
        check("frame_reads", 32'(m_reads), 32'd256);
        check("frame_first", 32'(m_first), 32'(e_first));
        check("frame_last", 32'(m_last), 32'(e_last));
        check("peak_value", 32'(peak_value), 32'(e_peak));
        check("peak_index", 32'(peak_index), 32'(e_idx));
        check("frame_coord", 32'(frame_coord), 32'(v.coord));
        tick(2);
        check("done_holds", 32'(done), 32'd1);
        check("peak_holds", 32'(peak_value), 32'(e_peak));
        do_rearm();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int   cyc;
        vec_t rv;

        vecs[0] = '{8'h10, PAT_RAMP,   13'h0123, 0, 0, 1'b0, 16'h0010, 16'h000F, 16'h00FF, 8'hEF, 768};
        vecs[1] = '{8'h00, PAT_SPIKES, 13'h0456, 1, 2, 1'b0, 16'h0005, 16'h0005, 16'h0800, 8'h20, 0};
        vecs[2] = '{8'h30, PAT_SPIKES, 13'h1FFF, 0, 3, 1'b0, 16'h0005, 16'h0005, 16'h0800, 8'h10, 0};
        vecs[3] = '{8'hFF, PAT_RAMP,   13'h0000, 1, 1, 1'b0, 16'h00FF, 16'h00FE, 16'h00FF, 8'h00, 0};
        vecs[4] = '{8'h80, PAT_ZERO,   13'h0AAA, 0, 0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 768};
        vecs[5] = '{8'h05, PAT_RAMP,   13'h0001, 2, 0, 1'b0, 16'h0005, 16'h0004, 16'h00FF, 8'hFA, 0};

        rearm = 1'b0;
        reset = 1'b1;

        // Level already high when reset releases counts as a start edge.
        fill_mem(PAT_RAMP);
        exp_ptr = 8'h10;
        ram_ptr = 8'h10;
        pulse_abs_coord = 13'h1ABC;
        buffer_full = 1'b1;
        ready_mode = 0;
        lat_max = 0;
        frame_id++;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        wait_done("bf_high_at_reset", 8000, cyc);
        check("bf_high_beats", 32'(m_beats), 32'd256);
        check("bf_high_coord", 32'(frame_coord), 32'h1ABC);
        check("bf_high_peak_index", 32'(peak_index), 32'hEF);
        do_rearm();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        for (int i = 0; i < 3; i++) begin
            rv = '{8'($urandom), (i == 1) ? PAT_RWIDE : PAT_RSMALL, 13'($urandom), 1,
                   int'($urandom_range(3, 0)), 1'b1, '0, '0, '0, '0, 0};
            run_vec(rv);
        end

        // Rearm and buffer_full edges mid-frame are ignored; no retrigger on a held level.
        fill_mem(PAT_RAMP);
        ready_mode = 3;
        lat_max = 0;
        start_frame(8'h20, 13'h0777);
        cyc = 0;
        while (!st_valid && cyc < 20) begin tick(1); cyc++; end
        check("push_reached", 32'(st_valid), 32'd1);
        rearm = 1'b1;
        buffer_full = 1'b0;
        tick(1);
        rearm = 1'b0;
        buffer_full = 1'b1;
        tick(1);
        check("rearm_in_push_done", 32'(done), 32'd0);
        check("rearm_in_push_valid", 32'(st_valid), 32'd1);
        ready_mode = 0;
        wait_done("rearm_push", 8000, cyc);
        check("rearm_push_beats", 32'(m_beats), 32'd256);
        check("rearm_push_first", 32'(m_first), 32'h0020);
        do_rearm();
        tick(20);
        check("held_level_no_reads", 32'(m_reads), 32'd256);
        check("held_level_no_done", 32'(done), 32'd0);
        check("held_level_idle", 32'(st_valid), 32'd0);
        start_frame(8'h20, 13'h0778);
        wait_done("retrigger", 8000, cyc);
        check("retrigger_beats", 32'(m_beats), 32'd256);
        check("retrigger_coord", 32'(frame_coord), 32'h0778);
        do_rearm();

        // Reset at beat 100 abandons the frame; the next edge starts from word 0.
        fill_mem(PAT_RAMP);
        ready_mode = 1;
        lat_max = 1;
        start_frame(8'h40, 13'h0321);
        cyc = 0;
        while (m_beats < 100 && cyc < 3000) begin tick(1); cyc++; end
        check("beat100_reached", 32'(m_beats), 32'd100);
        #2;
        reset = 1'b1;
        buffer_full = 1'b0;
        #1;
        check_all_zero("mid_reset");
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("in_reset_no_read", 32'(av_read), 32'd0);
        end
        reset = 1'b0;
        tick(5);
        check_all_zero("idle_after_reset");
        run_vec('{8'h40, PAT_RAMP, 13'h0999, 0, 0, 1'b0, 16'h0040, 16'h003F, 16'h00FF, 8'hBF, 768});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
